booth_mac_accumulator: RTL and testbench

Downstream consumer of the N-bit Booth multiplier top. It samples each signed 2N-bit product on the rising edge of the multiplier's done, sign-extends it and accumulates FRAME products into a guarded accumulator. It then presents the frame sum on a valid/ready output port. Accumulation of the next frame overlaps with the held output, so the multiplier never stalls while the sink is slow.

---
 rtl/booth_pkg.sv | 17 +
 rtl/booth_done_edge.sv | 22 ++
 rtl/booth_mac_accumulator.sv | 109 ++++++++++
 tb/tb_booth_mac_accumulator.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and width helpers for the Booth multiplier accumulator slice.
package booth_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  function automatic int acc_width(input int n, input int g);
    return 2 * n + g;
  endfunction

  function automatic int frame_cnt_width(input int frame);
    return $clog2(frame + 1);
  endfunction

endpackage

// File: rtl/booth_done_edge.sv
// Registered rising-edge detector on the multiplier done level.
module booth_done_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic prod_done,
  output logic ev
);

  logic done_d_reg;

  // Resetting to 1 keeps a done level that is already high at reset release from counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_d_reg <= 1'b1;
    end else begin
      done_d_reg <= prod_done;
    end
  end

  assign ev = prod_done && !done_d_reg;

endmodule

// File: rtl/booth_mac_accumulator.sv
// Frame accumulator for Booth products with a single-slot valid/ready result port.
module booth_mac_accumulator
  import booth_pkg::*;
#(
  parameter int N     = 4,
  parameter int G     = 4,
  parameter int FRAME = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 acc_clr,
  input  logic [2*N-1:0]                       prod_in,
  input  logic                                 prod_done,
  output logic [acc_width(N, G)-1:0]           res_data,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic                                 overrun,
  output logic [frame_cnt_width(FRAME)-1:0]    frame_cnt
);

  localparam int ACC_W = acc_width(N, G);
  localparam int CW    = frame_cnt_width(FRAME);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

  logic             ev;
  logic [ACC_W-1:0] sext_prod;
  logic [ACC_W-1:0] sum;
  logic             last;
  logic             slot_free;

  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [ACC_W-1:0] res_data_reg, res_data_next;
  logic             overrun_reg, overrun_next;
  out_state_t       state_reg, state_next;

  booth_done_edge u_done_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .prod_done (prod_done),
    .ev        (ev)
  );

  assign sext_prod[2*N-1:0] = prod_in;
  for (genvar gi = 0; gi < G; gi++) begin : g_sext
    assign sext_prod[2*N+gi] = prod_in[2*N-1];
  end

  assign sum       = acc_reg + sext_prod;
  assign last      = (cnt_reg == LAST_CNT);
  assign slot_free = (state_reg == OUT_EMPTY) || res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg      <= '0;
      cnt_reg      <= '0;
      res_data_reg <= '0;
      overrun_reg  <= 1'b0;
      state_reg    <= OUT_EMPTY;
    end else begin
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      res_data_reg <= res_data_next;
      overrun_reg  <= overrun_next;
      state_reg    <= state_next;
    end
  end

  always_comb begin
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    res_data_next = res_data_reg;
    overrun_next  = overrun_reg;
    state_next    = state_reg;

    if (acc_clr) begin
      acc_next     = '0;
      cnt_next     = '0;
      overrun_next = 1'b0;
      state_next   = OUT_EMPTY;
    end else begin
      if (state_reg == OUT_FULL && res_ready) begin
        state_next = OUT_EMPTY;
      end
      if (ev) begin
        if (last) begin
          acc_next = '0;
          cnt_next = '0;
          // A completion landing on an accepted slot reloads it without a bubble.
          if (slot_free) begin
            res_data_next = sum;
            state_next    = OUT_FULL;
          end else begin
            overrun_next = 1'b1;
          end
        end else begin
          acc_next = sum;
          cnt_next = cnt_reg + CW'(1);
        end
      end
    end
  end

  assign res_data  = res_data_reg;
  assign res_valid = (state_reg == OUT_FULL);
  assign overrun   = overrun_reg;
  assign frame_cnt = cnt_reg;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed bench for booth_mac_accumulator with N=4, G=4, FRAME=4.
module tb_booth_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc_clr = 1'b0;
  logic [7:0]  prod_in = '0;
  logic        prod_done = 1'b0;
  logic [11:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        overrun;
  logic [2:0]  frame_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_mac_accumulator #(.N(4), .G(4), .FRAME(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_clr   (acc_clr),
    .prod_in   (prod_in),
    .prod_done (prod_done),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // One-cycle done pulse; returns at the negedge after the sampling edge.
  task automatic pulse(input logic [7:0] p);
    @(negedge clk);
    prod_in   = p;
    prod_done = 1'b1;
    @(negedge clk);
    prod_done = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check_eq("rst_valid", {31'b0, res_valid}, 32'h0);
    check_eq("rst_data", {20'b0, res_data}, 32'h0);
    check_eq("rst_cnt", {29'b0, frame_cnt}, 32'h0);
    check_eq("rst_ovr", {31'b0, overrun}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mixed-sign frame: 15 - 14 + 6 - 8 = -1
    res_ready = 1'b1;
    pulse(8'h0F);
    pulse(8'hF2);
    check_eq("t1_cnt2", {29'b0, frame_cnt}, 32'h2);
    pulse(8'h06);
    pulse(8'hF8);
    check_eq("t1_valid", {31'b0, res_valid}, 32'h1);
    check_eq("t1_data", {20'b0, res_data}, 32'hFFF);
    check_eq("t1_ovr", {31'b0, overrun}, 32'h0);
    @(negedge clk);
    check_eq("t1_valid_drop", {31'b0, res_valid}, 32'h0);

    // 4 x 64 = 256, last done held high
    pulse(8'h40);
    pulse(8'h40);
    pulse(8'h40);
    @(negedge clk);
    prod_in   = 8'h40;
    prod_done = 1'b1;
    @(negedge clk);
    check_eq("t2_data", {20'b0, res_data}, 32'h100);
    check_eq("t2_valid", {31'b0, res_valid}, 32'h1);
    repeat (10) @(negedge clk);
    check_eq("t2_hold_cnt", {29'b0, frame_cnt}, 32'h0);
    check_eq("t2_hold_valid", {31'b0, res_valid}, 32'h0);
    prod_done = 1'b0;

    // Overrun: frames summing 4 then 8 with the sink stalled
    res_ready = 1'b0;
    repeat (4) pulse(8'h01);
    check_eq("t3_data4", {20'b0, res_data}, 32'h004);
    repeat (4) pulse(8'h02);
    check_eq("t3_data_kept", {20'b0, res_data}, 32'h004);
    check_eq("t3_ovr", {31'b0, overrun}, 32'h1);
    check_eq("t3_valid", {31'b0, res_valid}, 32'h1);
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("t3_accept", {31'b0, res_valid}, 32'h0);
    check_eq("t3_ovr_sticky", {31'b0, overrun}, 32'h1);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    check_eq("t3_clr_ovr", {31'b0, overrun}, 32'h0);

    // Accept and completion in the same cycle
    res_ready = 1'b0;
    pulse(8'h01);
    pulse(8'h02);
    pulse(8'h03);
    pulse(8'h04);
    check_eq("t4_data10", {20'b0, res_data}, 32'h00A);
    pulse(8'h05);
    pulse(8'h05);
    pulse(8'h05);
    @(negedge clk);
    res_ready = 1'b1;
    prod_in   = 8'h05;
    prod_done = 1'b1;
    @(negedge clk);
    prod_done = 1'b0;
    check_eq("t4_valid", {31'b0, res_valid}, 32'h1);
    check_eq("t4_data20", {20'b0, res_data}, 32'h014);
    check_eq("t4_ovr", {31'b0, overrun}, 32'h0);
    @(negedge clk);
    check_eq("t4_drain", {31'b0, res_valid}, 32'h0);

    // acc_clr coincident with an event at frame_cnt=2
    pulse(8'h07);
    pulse(8'h07);
    check_eq("t5_cnt2", {29'b0, frame_cnt}, 32'h2);
    @(negedge clk);
    prod_in   = 8'h09;
    prod_done = 1'b1;
    acc_clr   = 1'b1;
    @(negedge clk);
    acc_clr   = 1'b0;
    prod_done = 1'b0;
    check_eq("t5_clr_cnt", {29'b0, frame_cnt}, 32'h0);
    check_eq("t5_clr_valid", {31'b0, res_valid}, 32'h0);
    pulse(8'h03);
    pulse(8'hFE);
    pulse(8'h0A);
    pulse(8'hEC);
    check_eq("t5_data", {20'b0, res_data}, 32'hFF7);
    check_eq("t5_valid", {31'b0, res_valid}, 32'h1);

    // Reset mid-frame with done held high across release
    pulse(8'h01);
    pulse(8'h01);
    @(negedge clk);
    prod_done = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_cnt", {29'b0, frame_cnt}, 32'h0);
    check_eq("t6_rst_valid", {31'b0, res_valid}, 32'h0);
    check_eq("t6_rst_data", {20'b0, res_data}, 32'h0);
    check_eq("t6_rst_ovr", {31'b0, overrun}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_no_event", {29'b0, frame_cnt}, 32'h0);
    prod_done = 1'b0;
    pulse(8'h02);
    check_eq("t6_cnt1", {29'b0, frame_cnt}, 32'h1);
    pulse(8'h02);
    pulse(8'h02);
    pulse(8'h02);
    check_eq("t6_data", {20'b0, res_data}, 32'h008);
    check_eq("t6_valid", {31'b0, res_valid}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
